fifo_wr_arbiter: RTL and testbench

- Write-side controller for the asynchronous FIFO, in the write clock domain.
- Shares the single FIFO write port among NUM_REQ requesters using round-robin arbitration.
- Owns the binary/Gray write pointer, drives memory write enable, address and data.
- Computes full, almost-full and fill level against the read pointer after it has been synchronized into the write domain.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/fifo_wr_arbiter.sv | 88 ++++++++
 tb/tb_fifo_wr_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: default widths and Gray-code conversion.
// The conversion functions work on zero-extended values up to 32 bits; callers truncate.
package fifo_pkg;

  localparam int unsigned DefAddrWidth = 9;
  localparam int unsigned DefDataWidth = 8;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant plus the registered last-winner pointer.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IdxW-1:0]    gnt_idx,
  output logic               gnt_any
);

  logic [IdxW-1:0] last_gnt;
  logic [IdxW-1:0] idx;

  // Search begins one past the previous winner so every requester gets a turn.
  always_comb begin
    gnt     = '0;
    gnt_idx = last_gnt;
    gnt_any = 1'b0;
    idx     = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      idx = IdxW'((int'(last_gnt) + k) % int'(NUM_REQ));
      if (!gnt_any && en && !rst && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        gnt_any  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= IdxW'(NUM_REQ - 1);
    end else if (gnt_any) begin
      last_gnt <= gnt_idx;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side controller of the async FIFO: arbitrates requesters onto the single write port
// and tracks write pointer, full, almost-full and level against the synchronized read pointer.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned Addr_Width   = DefAddrWidth,
  parameter int unsigned Data_Width   = DefDataWidth,
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned AFULL_THRESH = 2 ** Addr_Width - 4,
  localparam int unsigned PtrW = Addr_Width + 1,
  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*Data_Width-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic [PtrW-1:0]               rptr_s,
  output logic [PtrW-1:0]               wptr,
  output logic                          wen,
  output logic [Addr_Width-1:0]         waddr,
  output logic [Data_Width-1:0]         wdata,
  output logic                          wfull,
  output logic                          walmost_full,
  output logic [PtrW-1:0]               wlevel
);

  logic [PtrW-1:0]       wbin;
  logic [PtrW-1:0]       wbin_next;
  logic [PtrW-1:0]       wgray_next;
  logic [PtrW-1:0]       rbin;
  logic [PtrW-1:0]       rgray_full;
  logic [PtrW-1:0]       level_next;
  logic                  full_next;
  logic                  afull_next;
  logic [IdxW-1:0]       gnt_idx;
  logic                  gnt_any;
  logic [Data_Width-1:0] sel_data;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .clk    (wclk),
    .rst    (wrst),
    .en     (~wfull),
    .req    (req),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .gnt_any(gnt_any)
  );

  // Flags are computed from the post-write pointer so a full FIFO can never be overrun.
  always_comb begin
    wbin_next  = wbin + PtrW'(gnt_any);
    wgray_next = PtrW'(bin2gray(32'(wbin_next)));
    rbin       = PtrW'(gray2bin(32'(rptr_s)));
    rgray_full = {~rptr_s[Addr_Width:Addr_Width-1], rptr_s[Addr_Width-2:0]};
    full_next  = (wgray_next == rgray_full);
    level_next = wbin_next - rbin;
    afull_next = (32'(level_next) >= AFULL_THRESH);
    sel_data   = req_data[int'(gnt_idx)*Data_Width +: Data_Width];
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin         <= '0;
      wptr         <= '0;
      wen          <= 1'b0;
      waddr        <= '0;
      wdata        <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wen          <= gnt_any;
      if (gnt_any) begin
        waddr <= wbin[Addr_Width-1:0];
        wdata <= sel_data;
      end
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= full_next;
      walmost_full <= afull_next;
      wlevel       <= level_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (depth 16, four requesters) with a count-based model.
module tb_fifo_wr_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int DEPTH = 16;
  localparam int PMOD = 32;
  localparam int THRESH = 12;

  logic           wclk = 1'b0;
  logic           wrst;
  logic [NR-1:0]  req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  gnt;
  logic [AW:0]    rptr_s;
  logic [AW:0]    wptr;
  logic           wen;
  logic [AW-1:0]  waddr;
  logic [DW-1:0]  wdata;
  logic           wfull;
  logic           walmost_full;
  logic [AW:0]    wlevel;

  int n_vec = 0;
  int n_fail = 0;

  fifo_wr_arbiter #(
    .Addr_Width  (AW),
    .Data_Width  (DW),
    .NUM_REQ     (NR),
    .AFULL_THRESH(THRESH)
  ) dut (
    .wclk        (wclk),
    .wrst        (wrst),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .rptr_s      (rptr_s),
    .wptr        (wptr),
    .wen         (wen),
    .waddr       (waddr),
    .wdata       (wdata),
    .wfull       (wfull),
    .walmost_full(walmost_full),
    .wlevel      (wlevel)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW:0] gray5(input int v);
    logic [AW:0] b;
    b = (AW + 1)'(v % PMOD);
    return b ^ (b >> 1);
  endfunction

  // Decode by search: the read count is the binary value whose Gray code matches.
  function automatic int ungray5(input logic [AW:0] g);
    for (int v = 0; v < PMOD; v++) begin
      if (gray5(v) == g) return v;
    end
    return 0;
  endfunction

  function automatic logic [DW-1:0] slice(input int i);
    return req_data[i*DW +: DW];
  endfunction

  // Model: writes counted mod 2*depth; level is writes minus reads; full means level == depth.
  int          m_w;
  int          m_last;
  int          m_level;
  logic        m_valid = 1'b0;
  logic        m_wen, m_full, m_afull;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;

  always @(negedge wclk) begin
    int win;
    logic [NR-1:0] exp_gnt;
    win = -1;
    exp_gnt = '0;
    if (!wrst && m_valid && !m_full) begin
      for (int k = 1; k <= NR; k++) begin
        if (win < 0 && req[(m_last + k) % NR]) win = (m_last + k) % NR;
      end
    end
    if (win >= 0) exp_gnt[win] = 1'b1;
    if (m_valid) begin
      chk("wptr", 32'(wptr), 32'(gray5(m_w)));
      chk("wen", 32'(wen), 32'(m_wen));
      chk("waddr", 32'(waddr), 32'(m_waddr));
      chk("wdata", 32'(wdata), 32'(m_wdata));
      chk("wfull", 32'(wfull), 32'(m_full));
      chk("walmost_full", 32'(walmost_full), 32'(m_afull));
      chk("wlevel", 32'(wlevel), 32'(m_level));
      chk("gnt", 32'(gnt), 32'(exp_gnt));
    end
    if (wrst) begin
      m_valid = 1'b1;
      m_w = 0; m_last = NR - 1; m_wen = 0; m_waddr = '0; m_wdata = '0;
      m_full = 0; m_afull = 0; m_level = 0;
    end else if (m_valid) begin
      m_wen = (win >= 0);
      if (win >= 0) begin
        m_waddr = AW'(m_w % DEPTH);
        m_wdata = slice(win);
        m_w = (m_w + 1) % PMOD;
        m_last = win;
      end
      m_level = ((m_w - ungray5(rptr_s)) % PMOD + PMOD) % PMOD;
      m_full = (m_level == DEPTH);
      m_afull = (m_level >= THRESH);
    end
  end

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  initial begin
    logic [NR-1:0] ord [6];
    int n;
    int bad;
    logic seen;
    logic [AW:0] prev;
    ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    wrst = 1'b1; req = 4'hF; rptr_s = '0;

    // Reset with all requesters active
    tick(); tick();
    #1 chk("gnt_in_reset", 32'(gnt), 32'h0);
    tick();
    wrst = 1'b0; req = '0;
    tick();
    #1;
    chk("rst_wptr", 32'(wptr), 32'h0);
    chk("rst_wen", 32'(wen), 32'h0);
    chk("rst_wfull", 32'(wfull), 32'h0);
    chk("rst_wlevel", 32'(wlevel), 32'h0);

    // Round-robin order with everyone requesting
    req = 4'hF;
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_order", 32'(gnt), 32'(ord[k]));
      if (k > 0) chk("rr_wdata", 32'(wdata), 32'(8'h11 * ($clog2(ord[k-1]) + 1)));
      tick();
    end
    req = '0;

    // Fill to full with a single requester
    wrst = 1'b1; rptr_s = '0;
    tick();
    wrst = 1'b0; req = 4'b0001;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (wfull) break;
      if (gnt == 4'b0001) n++;
      tick();
    end
    chk("fill_grants", 32'(n), 32'd16);
    chk("fill_wfull", 32'(wfull), 32'h1);
    chk("fill_wlevel", 32'(wlevel), 32'd16);
    chk("fill_wptr", 32'(wptr), 32'b11000);
    chk("fill_gnt", 32'(gnt), 32'h0);
    chk("fill_last_waddr", 32'(waddr), 32'd15);

    // One read frees one slot
    tick();
    rptr_s = 5'b00001;
    #1 chk("adv_gnt_held", 32'(gnt), 32'h0);
    tick();
    #1;
    chk("adv_wfull_clr", 32'(wfull), 32'h0);
    chk("adv_wlevel", 32'(wlevel), 32'd15);
    chk("adv_gnt", 32'(gnt), 32'b0001);
    tick();
    #1;
    chk("adv_wfull_set", 32'(wfull), 32'h1);
    chk("adv_waddr", 32'(waddr), 32'h0);
    req = '0;

    // Wrap with the reader eight behind
    wrst = 1'b1; rptr_s = '0;
    tick();
    wrst = 1'b0; req = 4'b0001;
    prev = '0; bad = 0; seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c >= 8) rptr_s = gray5(c - 7);
      tick();
      #1;
      if ($countones(wptr ^ prev) != 1) bad++;
      if (prev == 5'b10000 && wptr == 5'b00000) seen = 1'b1;
      prev = wptr;
      if (c >= 7) chk("wrap_wlevel", 32'(wlevel), 32'd8);
    end
    chk("wrap_gray_steps", 32'(bad), 32'd0);
    chk("wrap_seen_10000_to_0", 32'(seen), 32'h1);
    chk("wrap_afull", 32'(walmost_full), 32'h0);

    // Reset in the middle of a burst
    req = 4'b0110;
    tick(); tick(); tick();
    wrst = 1'b1;
    #1 chk("midrst_gnt", 32'(gnt), 32'h0);
    tick();
    #1;
    chk("midrst_wen", 32'(wen), 32'h0);
    chk("midrst_wptr", 32'(wptr), 32'h0);
    chk("midrst_waddr", 32'(waddr), 32'h0);
    chk("midrst_wdata", 32'(wdata), 32'h0);
    chk("midrst_wlevel", 32'(wlevel), 32'h0);
    wrst = 1'b0;
    #1 chk("midrst_first_gnt", 32'(gnt), 32'b0010);
    tick();
    #1 chk("midrst_first_wdata", 32'(wdata), 32'h22);
    req = '0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
